// File: rtl/ro_measure_sequencer.sv
// Ring-oscillator measurement sequencer: walks a masked set of ROs, gates the shared
// frequency counter for a programmable window, and streams each count out over valid/ready.
module ro_measure_sequencer #(
    parameter int NUM_RO        = 8,
    parameter int SEL_WIDTH     = 3,
    parameter int COUNT_WIDTH   = 16,
    parameter int WINDOW_WIDTH  = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [NUM_RO-1:0]       ro_mask,
    input  logic [WINDOW_WIDTH-1:0] window_len,
    input  logic [COUNT_WIDTH-1:0]  cnt_value,
    output logic                    busy,
    output logic [SEL_WIDTH-1:0]    ro_sel,
    output logic                    ro_enable,
    output logic                    cnt_enable,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic [SEL_WIDTH-1:0]    result_idx,
    output logic [COUNT_WIDTH-1:0]  result_count,
    output logic                    done
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = (WINDOW_WIDTH > SW) ? WINDOW_WIDTH : SW;

    typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, HOLD, RESULT, FINISH} state_t;

    state_t                  state_q, state_d;
    logic [SEL_WIDTH-1:0]    idx_q, idx_d;
    logic [NUM_RO-1:0]       mask_q, mask_d;
    logic [WINDOW_WIDTH-1:0] win_q, win_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic                    busy_q, busy_d, ro_enable_q, ro_enable_d;
    logic                    cnt_enable_q, cnt_enable_d, result_valid_q, result_valid_d;
    logic                    done_q, done_d;
    logic [SEL_WIDTH-1:0]    ro_sel_q, ro_sel_d, result_idx_q, result_idx_d;
    logic [COUNT_WIDTH-1:0]  result_count_q, result_count_d;

    // Returns {found, index} of the lowest set mask bit at or above lo.
    function automatic logic [SEL_WIDTH:0] first_from(input logic [NUM_RO-1:0] m, input int lo);
        logic [SEL_WIDTH:0] r;
        r = '0;
        for (int i = NUM_RO - 1; i >= 0; i--)
            if (m[i] && i >= lo) r = {1'b1, SEL_WIDTH'(i)};
        return r;
    endfunction

    logic [SEL_WIDTH:0] first_hit, next_hit;
    assign first_hit = first_from(ro_mask, 0);
    assign next_hit  = first_from(mask_q, int'(idx_q) + 1);

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        mask_d         = mask_q;
        win_d          = win_q;
        timer_d        = timer_q;
        done_d         = 1'b0;
        result_count_d = result_count_q;
        result_idx_d   = result_idx_q;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    mask_d = ro_mask;
                    win_d  = window_len;
                    if (first_hit[SEL_WIDTH]) begin
                        idx_d   = first_hit[SEL_WIDTH-1:0];
                        timer_d = TW'(SETTLE_CYCLES - 1);
                        state_d = SETTLE;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            SETTLE: begin
                if (timer_q == '0) begin
                    timer_d = (win_q == '0) ? '0 : TW'(win_q) - TW'(1);
                    state_d = MEASURE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            MEASURE: begin
                if (timer_q == '0) state_d = HOLD;
                else               timer_d = timer_q - TW'(1);
            end
            HOLD: begin
                // Counter is already stopped but not yet cleared: this is the stable sample point.
                result_count_d = cnt_value;
                result_idx_d   = idx_q;
                state_d        = RESULT;
            end
            RESULT: begin
                if (result_ready) begin
                    if (next_hit[SEL_WIDTH]) begin
                        idx_d   = next_hit[SEL_WIDTH-1:0];
                        timer_d = TW'(SETTLE_CYCLES - 1);
                        state_d = SETTLE;
                    end else begin
                        done_d  = 1'b1;
                        state_d = FINISH;
                    end
                end
            end
            FINISH: begin
                // An empty scan arrives here without done set and pulses it one cycle later.
                if (done_q) state_d = IDLE;
                else        done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end

        busy_d         = (state_d != IDLE);
        ro_enable_d    = (state_d == SETTLE) || (state_d == MEASURE) || (state_d == HOLD);
        cnt_enable_d   = (state_d == MEASURE);
        result_valid_d = (state_d == RESULT);
        ro_sel_d       = (state_d == SETTLE) ? idx_d : ro_sel_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            mask_q         <= '0;
            win_q          <= '0;
            timer_q        <= '0;
            busy_q         <= 1'b0;
            ro_sel_q       <= '0;
            ro_enable_q    <= 1'b0;
            cnt_enable_q   <= 1'b0;
            result_valid_q <= 1'b0;
            result_idx_q   <= '0;
            result_count_q <= '0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            mask_q         <= mask_d;
            win_q          <= win_d;
            timer_q        <= timer_d;
            busy_q         <= busy_d;
            ro_sel_q       <= ro_sel_d;
            ro_enable_q    <= ro_enable_d;
            cnt_enable_q   <= cnt_enable_d;
            result_valid_q <= result_valid_d;
            result_idx_q   <= result_idx_d;
            result_count_q <= result_count_d;
            done_q         <= done_d;
        end
    end

    assign busy         = busy_q;
    assign ro_sel       = ro_sel_q;
    assign ro_enable    = ro_enable_q;
    assign cnt_enable   = cnt_enable_q;
    assign result_valid = result_valid_q;
    assign result_idx   = result_idx_q;
    assign result_count = result_count_q;
    assign done         = done_q;
endmodule
